// File: rtl/m_fm_modfeed.sv
// FM transmitter feeder: buffers signed audio samples, converts them at a programmable
// rate into addend words and writes those and control words to the transmitter.
module m_fm_modfeed #(
  parameter int FIFOAW = 4,
  parameter int DIVW   = 12,
  parameter int DEVSH  = 6
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [15:0] DAT_I,
  output logic        ACK_O,
  output logic [15:0] DAT_O,
  output logic        fmSTB_O,
  output logic        fmWE_O,
  output logic [14:0] fmDAT_O,
  input  logic        fmACK_I
);

  localparam int DEPTH = 1 << FIFOAW;
  localparam logic [FIFOAW:0] LVL_FULL = (FIFOAW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [15:0]       r_ctrl;
  logic [DIVW-1:0]   r_div, r_divcnt;
  logic [7:0]        r_mem [DEPTH];
  logic [FIFOAW-1:0] r_wptr, r_rptr;
  logic [FIFOAW:0]   r_level;
  logic              r_underrun, r_overflow, r_late;
  logic              r_cfg_pend, r_smp_pend;
  logic [12:0]       r_smp_add;
  state_t            r_state;
  logic              r_stb;
  logic [14:0]       r_dat;

  logic w_wr, w_wr_ctrl, w_push, w_clr, w_full, w_empty, w_tick, w_pop, w_push_ok;
  logic w_take_cfg, w_take_smp;
  logic signed [7:0]  w_s;
  logic signed [14:0] w_sext, w_sum;
  logic [12:0]        w_add;
  logic [15:0]        w_status;

  assign w_wr      = STB_I & WE_I;
  assign w_wr_ctrl = w_wr & (ADR_I == 2'd0);
  assign w_push    = w_wr & (ADR_I == 2'd1);
  assign w_clr     = w_wr & (ADR_I == 2'd3);
  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_tick    = r_ctrl[15] & (r_divcnt == '0);
  assign w_pop     = w_tick & ~w_empty;
  assign w_push_ok = w_push & ~w_full;

  assign w_take_cfg = (r_state == S_IDLE) & r_cfg_pend;
  assign w_take_smp = (r_state == S_IDLE) & ~r_cfg_pend & r_smp_pend;

  // Underrun feeds a zero sample, so the carrier sits at base.
  assign w_s    = w_empty ? 8'sd0 : $signed(r_mem[r_rptr]);
  assign w_sext = {{7{w_s[7]}}, w_s};
  assign w_sum  = $signed({2'b00, r_ctrl[12:0]}) + (w_sext >>> DEVSH);
  assign w_add  = w_sum[14] ? 13'd0 : (w_sum[13] ? 13'h1fff : w_sum[12:0]);

  assign ACK_O   = STB_I;
  assign fmSTB_O = r_stb;
  assign fmWE_O  = r_stb;
  assign fmDAT_O = r_dat;

  always_comb begin
    w_status           = '0;
    w_status[FIFOAW:0] = r_level;
    w_status[11]       = w_empty;
    w_status[12]       = w_full;
    w_status[13]       = r_late;
    w_status[14]       = r_overflow;
    w_status[15]       = r_underrun;
  end

  always_comb begin
    DAT_O = '0;
    case (ADR_I)
      2'd0:    DAT_O = r_ctrl;
      2'd1:    DAT_O = w_status;
      2'd2:    DAT_O = 16'(r_div);
      default: DAT_O = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (w_push_ok) r_mem[r_wptr] <= DAT_I[7:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ctrl   <= '0;
      r_div    <= '0;
      r_divcnt <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= DAT_I;
      if (w_wr && ADR_I == 2'd2) r_div <= DAT_I[DIVW-1:0];
      if (!r_ctrl[15] || r_divcnt == '0) r_divcnt <= r_div;
      else                               r_divcnt <= r_divcnt - 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a clear still sticks.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_late     <= 1'b0;
      r_smp_pend <= 1'b0;
      r_smp_add  <= '0;
      r_cfg_pend <= 1'b0;
    end else begin
      r_underrun <= (r_underrun & ~w_clr) | (w_tick & w_empty);
      r_overflow <= (r_overflow & ~w_clr) | (w_push & w_full);
      r_late     <= (r_late & ~w_clr) | (w_tick & r_smp_pend & ~w_take_smp);
      if (w_tick) begin
        r_smp_add  <= w_add;
        r_smp_pend <= 1'b1;
      end else if (w_take_smp) begin
        r_smp_pend <= 1'b0;
      end
      if (w_wr_ctrl)       r_cfg_pend <= 1'b1;
      else if (w_take_cfg) r_cfg_pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cfg_pend) begin
            r_dat   <= r_ctrl[14:0];
            r_stb   <= 1'b1;
            r_state <= S_REQ;
          end else if (r_smp_pend) begin
            r_dat   <= {r_ctrl[14:13], r_smp_add};
            r_stb   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (fmACK_I) begin
            r_stb   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_fm_modfeed.sv
// Bench for m_fm_modfeed: directed steps plus randomized samples, with expected
// addends computed arithmetically from base and a queue of pushed samples.
module tb_m_fm_modfeed;
  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        STB_I = 1'b0, WE_I = 1'b0;
  logic [1:0]  ADR_I = '0;
  logic [15:0] DAT_I = '0;
  logic        ACK_O;
  logic [15:0] DAT_O;
  logic        fmSTB_O, fmWE_O;
  logic [14:0] fmDAT_O;
  logic        fmACK_I = 1'b0;

  int n_chk = 0, n_pass = 0;
  int q[$];

  m_fm_modfeed #(.FIFOAW(4), .DIVW(12), .DEVSH(6)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .DAT_I(DAT_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .fmSTB_O(fmSTB_O),
    .fmWE_O(fmWE_O), .fmDAT_O(fmDAT_O), .fmACK_I(fmACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Carrier offset is floor(sample / 64), then clamped into the 13-bit range.
  function automatic int exp_add(input int base, input int s);
    int d, sum;
    d   = (s >= 0) ? s / 64 : -((-s + 63) / 64);
    sum = base + d;
    if (sum < 0)    sum = 0;
    if (sum > 8191) sum = 8191;
    return sum;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge CLK_I);
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = a; DAT_I = d;
    #1 chk("ack", ACK_O, 1);
    @(negedge CLK_I);
    STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    ADR_I = a;
    #1 d = DAT_O;
  endtask

  task automatic push(input int s);
    wr(2'd1, 16'(s & 8'hff));
    if (q.size() < 16) q.push_back((s & 8'h80) ? (s & 8'hff) - 256 : (s & 8'hff));
  endtask

  task automatic get_xfer(input string tag, input logic [14:0] exp, input int hold);
    int n;
    n = 0;
    while (fmSTB_O !== 1'b1 && n < 300) begin
      @(negedge CLK_I);
      n++;
    end
    if (fmSTB_O !== 1'b1) begin
      chk({tag, "_timeout"}, fmSTB_O, 1);
      return;
    end
    chk(tag, fmDAT_O, exp);
    chk({tag, "_we"}, fmWE_O, 1);
    repeat (hold) @(negedge CLK_I);
    if (hold > 0) begin
      chk({tag, "_stable"}, fmDAT_O, exp);
      chk({tag, "_held"}, fmSTB_O, 1);
    end
    fmACK_I = 1'b1;
    @(negedge CLK_I);
    fmACK_I = 1'b0;
    chk({tag, "_drop"}, fmSTB_O, 0);
  endtask

  task automatic drain();
    repeat (40) begin
      @(negedge CLK_I);
      fmACK_I = fmSTB_O;
    end
    fmACK_I = 1'b0;
  endtask

  // Run with ctrl (run bit added here) until nsamp queued plus nunder underrun words arrive.
  task automatic play(input logic [15:0] ctrl, input int nsamp, input int nunder);
    int base;
    logic [14:0] e;
    base = int'(ctrl[12:0]);
    wr(2'd0, ctrl | 16'h8000);
    get_xfer("cfg", ctrl[14:0], 1);
    for (int i = 0; i < nsamp; i++) begin
      e = {ctrl[14:13], 13'(exp_add(base, q.pop_front()))};
      get_xfer("smp", e, 0);
    end
    for (int i = 0; i < nunder; i++) begin
      e = {ctrl[14:13], 13'(exp_add(base, 0))};
      get_xfer("undr", e, 0);
    end
    wr(2'd0, ctrl);
    drain();
  endtask

  initial begin
    logic [15:0] st;
    logic [15:0] c;
    int n, rb;

    // reset state
    repeat (3) @(negedge CLK_I);
    chk("rst_stb", fmSTB_O, 0);
    chk("rst_dat", fmDAT_O, 0);
    rd(2'd0, st); chk("rst_ctrl", st, 16'h0000);
    rd(2'd1, st); chk("rst_status", st, 16'h0800);
    rd(2'd2, st); chk("rst_div", st, 16'h0000);
    RST_I = 1'b0;

    // control write forwarded as one transfer
    wr(2'd0, 16'h6100);
    get_xfer("t1_cfg", 15'h6100, 3);
    rd(2'd0, st); chk("t1_ctrl_rd", st, 16'h6100);
    wr(2'd2, 16'd9);
    rd(2'd2, st); chk("div_rd", st, 16'd9);
    rd(2'd3, st); chk("adr3_rd", st, 16'h0000);

    // fixed samples then one underrun
    push(8'h40); push(8'hC0); push(8'h7F);
    rd(2'd1, st); chk("t2_level", st, 16'h0003);
    play(16'h6100, 3, 1);
    rd(2'd1, st); chk("t2_status", st, 16'h8800);

    // randomized base/flags/samples
    for (int r = 0; r < 3; r++) begin
      c = 16'($urandom_range(0, 16'h7fff)) & 16'h7fff;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) push($urandom_range(0, 255));
      play(c, n, 0);
    end

    // saturation both ways
    wr(2'd3, 16'h0);
    push(8'h7F);
    play(16'h5FFF, 1, 0);
    push(8'h80);
    play(16'h4000, 1, 0);

    // overflow with run=0
    wr(2'd3, 16'h0);
    for (int i = 0; i < 17; i++) push(i);
    rd(2'd1, st); chk("t3_full", st, 16'h5010);
    wr(2'd3, 16'h0);
    rd(2'd1, st); chk("t3_clr", st, 16'h1010);

    // async reset mid-transfer
    push(8'h55);
    rd(2'd1, st); chk("t6_ovf", st[14], 1);
    wr(2'd0, 16'h6000);
    n = 0;
    while (fmSTB_O !== 1'b1 && n < 50) begin @(negedge CLK_I); n++; end
    chk("t6_req", fmSTB_O, 1);
    RST_I = 1'b1;
    #1;
    chk("t6_stb", fmSTB_O, 0);
    chk("t6_we", fmWE_O, 0);
    chk("t6_dat", fmDAT_O, 0);
    rd(2'd1, st); chk("t6_status", st, 16'h0800);
    rd(2'd0, st); chk("t6_ctrl", st, 16'h0000);
    q.delete();
    @(negedge CLK_I);
    RST_I = 1'b0;

    // late: div=0 and a stalled transfer
    wr(2'd2, 16'd0);
    for (int i = 0; i < 3; i++) push($urandom_range(0, 255));
    rb = $urandom_range(200, 8000);
    c  = 16'h6000 | 16'(rb);
    wr(2'd0, c | 16'h8000);
    get_xfer("t5_cfg", c[14:0], 5);
    get_xfer("t5_new", {2'b11, 13'(exp_add(rb, 0))}, 0);
    rd(2'd1, st); chk("t5_status", st, 16'hA800);
    q.delete();
    wr(2'd0, c);
    drain();
    rd(2'd1, st); chk("t5_empty", st[11:0], 12'h800);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
